// File: rtl/uart_pkg.sv
// Shared UART constants and types used by uart_rx and uart_tx.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT   = 87;
  localparam int UART_DATA_WIDTH_DEF = 8;
  localparam int UART_DATA_WIDTH_MIN = 5;
  localparam int UART_DATA_WIDTH_MAX = 9;
  localparam int UART_CLKS_PER_BIT_MIN = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  // Offset from a bit edge to its centre, in clock cycles.
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pins; output lags the input by 2 cycles.
// No flow control; reset value is a parameter so idle-high lines stay quiet.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style frames sampled mid-bit; valid 830 cycles after the start edge at defaults.
// No backpressure and no buffer: dout must be captured on the valid pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH_DEF,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  serial_rx,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] HALF_C   = CW'(half_bit(CLKS_PER_BIT));
  localparam logic [CW-1:0] LAST_C   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_START     = START;
  localparam logic [2:0] S_DATA      = DATA;
  localparam logic [2:0] S_STOP      = STOP;
  localparam logic [2:0] S_WAIT_HIGH = WAIT_HIGH;

  if (DATA_WIDTH < UART_DATA_WIDTH_MIN || DATA_WIDTH > UART_DATA_WIDTH_MAX) begin : g_bad_width
    $error("uart_rx: DATA_WIDTH outside supported range");
  end
  if (CLKS_PER_BIT < UART_CLKS_PER_BIT_MIN) begin : g_bad_rate
    $error("uart_rx: CLKS_PER_BIT too small");
  end

  logic                  rx_s;
  logic [2:0]            state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         index, index_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic [DATA_WIDTH-1:0] dout_n;
  logic                  valid_n, ferr_n;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (serial_rx),
    .q       (rx_s)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    index_n = index;
    shift_n = shift;
    dout_n  = dout;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n   = '0;
        index_n = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        // Start bit is only judged at its centre; a short low pulse is dropped there.
        if (cnt == HALF_C) begin
          cnt_n   = '0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt == LAST_C) begin
          cnt_n          = '0;
          shift_n[index] = rx_s;
          if (index == LAST_IDX) begin
            index_n = '0;
            state_n = S_STOP;
          end else begin
            index_n = index + IW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be seen in IDLE.
        if (cnt == LAST_C) begin
          cnt_n = '0;
          if (rx_s) begin
            dout_n  = shift;
            valid_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        index_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      index     <= '0;
      shift     <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      index     <= index_n;
      shift     <= shift_n;
      dout      <= dout_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
      busy      <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default 8-bit/87 instance plus 5-bit/4 and 9-bit/87 instances.
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic rx_a, rx_b, rx_c;

  logic [7:0] dout_a;
  logic       valid_a, ferr_a, busy_a;
  logic [4:0] dout_b;
  logic       valid_b, ferr_b, busy_b;
  logic [8:0] dout_c;
  logic       valid_c, ferr_c, busy_c;

  uart_rx #(.DATA_WIDTH(8), .CLKS_PER_BIT(87)) dut_a (
    .clk(clk), .reset_n(reset_n), .serial_rx(rx_a),
    .dout(dout_a), .valid(valid_a), .frame_err(ferr_a), .busy(busy_a)
  );
  uart_rx #(.DATA_WIDTH(5), .CLKS_PER_BIT(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .serial_rx(rx_b),
    .dout(dout_b), .valid(valid_b), .frame_err(ferr_b), .busy(busy_b)
  );
  uart_rx #(.DATA_WIDTH(9), .CLKS_PER_BIT(87)) dut_c (
    .clk(clk), .reset_n(reset_n), .serial_rx(rx_c),
    .dout(dout_c), .valid(valid_c), .frame_err(ferr_c), .busy(busy_c)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors, sampled on the falling edge.
  int va_cnt = 0, fa_cnt = 0, both_cnt = 0, busy_hi = 0;
  int fb_cnt = 0, fc_cnt = 0;
  logic [8:0] vqa[$], vqb[$], vqc[$];
  int cqa[$];

  always @(negedge clk) begin
    if (valid_a) begin
      va_cnt++;
      vqa.push_back({1'b0, dout_a});
      cqa.push_back(cyc);
    end
    if (ferr_a) fa_cnt++;
    if (valid_a && ferr_a) both_cnt++;
    if (busy_a) busy_hi++;
    if (valid_b) vqb.push_back({4'b0, dout_b});
    if (ferr_b) fb_cnt++;
    if (valid_c) vqc.push_back(dout_c);
    if (ferr_c) fc_cnt++;
  end

  int total = 0, passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input int n);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic [8:0] w, input int dw,
                            input int cpb, input logic stop_bit);
    drive(sel, 1'b0, cpb);
    for (int i = 0; i < dw; i++) drive(sel, w[i], cpb);
    drive(sel, stop_bit, cpb);
  endtask

  int t0, va0, fa0;

  initial begin
    reset_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    rx_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", dout_a, 8'h00);
    chk("reset_valid", valid_a, 1'b0);
    chk("reset_ferr", ferr_a, 1'b0);
    chk("reset_busy", busy_a, 1'b0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Single frame 0xA5
    t0 = cyc;
    send_frame(0, 9'h0A5, 8, 87, 1'b1);
    chk("single_count", va_cnt, 1);
    chk("single_dout", vqa[0], 9'h0A5);
    chk("single_latency", cqa[0] - t0, 830);
    chk("single_ferr", fa_cnt, 0);
    chk("single_hold", dout_a, 8'hA5);

    // Back-to-back frames with no idle gap
    vqa.delete();
    cqa.delete();
    t0 = cyc;
    send_frame(0, 9'h000, 8, 87, 1'b1);
    send_frame(0, 9'h0FF, 8, 87, 1'b1);
    send_frame(0, 9'h03C, 8, 87, 1'b1);
    drive(0, 1'b1, 20);
    chk("b2b_count", vqa.size(), 3);
    chk("b2b_dout0", vqa[0], 9'h000);
    chk("b2b_dout1", vqa[1], 9'h0FF);
    chk("b2b_dout2", vqa[2], 9'h03C);
    chk("b2b_latency0", cqa[0] - t0, 830);
    chk("b2b_gap01", cqa[1] - cqa[0], 870);
    chk("b2b_gap12", cqa[2] - cqa[1], 870);

    // Glitch: the start bit is only judged at mid-bit, so busy lasts HALF+1 = 44 cycles
    va0 = va_cnt;
    fa0 = fa_cnt;
    busy_hi = 0;
    drive(0, 1'b0, 20);
    drive(0, 1'b1, 100);
    chk("glitch_valid", va_cnt - va0, 0);
    chk("glitch_ferr", fa_cnt - fa0, 0);
    chk("glitch_busy_cycles", busy_hi, 44);
    chk("glitch_idle", busy_a, 1'b0);

    // Framing error followed by a long break
    va0 = va_cnt;
    fa0 = fa_cnt;
    send_frame(0, 9'h055, 8, 87, 1'b0);
    drive(0, 1'b0, 2000);
    chk("break_busy_held", busy_a, 1'b1);
    drive(0, 1'b1, 2);
    chk("release_busy_2", busy_a, 1'b1);
    drive(0, 1'b1, 1);
    chk("release_busy_3", busy_a, 1'b0);
    drive(0, 1'b1, 2000);
    chk("ferr_count", fa_cnt - fa0, 1);
    chk("ferr_no_valid", va_cnt - va0, 0);
    chk("ferr_dout_kept", dout_a, 8'h3C);
    chk("ferr_no_retrigger", busy_a, 1'b0);

    // Reset during data bit 4 of 0x81
    va0 = va_cnt;
    fa0 = fa_cnt;
    drive(0, 1'b0, 87);
    drive(0, 1'b1, 87);
    drive(0, 1'b0, 87);
    drive(0, 1'b0, 87);
    drive(0, 1'b0, 87);
    drive(0, 1'b0, 40);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("midreset_dout", dout_a, 8'h00);
    chk("midreset_busy", busy_a, 1'b0);
    chk("midreset_valid", valid_a, 1'b0);
    drive(0, 1'b1, 1000);
    chk("midreset_no_valid", va_cnt - va0, 0);
    chk("midreset_no_ferr", fa_cnt - fa0, 0);
    send_frame(0, 9'h042, 8, 87, 1'b1);
    chk("after_reset_count", va_cnt - va0, 1);
    chk("after_reset_dout", dout_a, 8'h42);

    // 5-bit, 4 clk/bit instance
    send_frame(1, 9'h015, 5, 4, 1'b1);
    send_frame(1, 9'h00A, 5, 4, 1'b1);
    send_frame(1, 9'h01F, 5, 4, 1'b1);
    send_frame(1, 9'h000, 5, 4, 1'b1);
    send_frame(1, 9'h011, 5, 4, 1'b1);
    drive(1, 1'b1, 20);
    chk("w5_count", vqb.size(), 5);
    chk("w5_d0", vqb[0], 9'h015);
    chk("w5_d1", vqb[1], 9'h00A);
    chk("w5_d2", vqb[2], 9'h01F);
    chk("w5_d3", vqb[3], 9'h000);
    chk("w5_d4", vqb[4], 9'h011);
    chk("w5_ferr", fb_cnt, 0);

    // 9-bit, 87 clk/bit instance
    send_frame(2, 9'h1A5, 9, 87, 1'b1);
    send_frame(2, 9'h100, 9, 87, 1'b1);
    send_frame(2, 9'h0FF, 9, 87, 1'b1);
    drive(2, 1'b1, 20);
    chk("w9_count", vqc.size(), 3);
    chk("w9_d0", vqc[0], 9'h1A5);
    chk("w9_d1", vqc[1], 9'h100);
    chk("w9_d2", vqc[2], 9'h0FF);
    chk("w9_ferr", fc_cnt, 0);

    chk("valid_ferr_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
